// File: rtl/fetch_if.sv
// Fetch-stage bus: control inputs from decode/execute, the instruction-memory
// port, and the instruction presented downstream.
interface fetch_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IMEM_AW = 6
);
  logic               stall;
  logic [1:0]         pc_sel;
  logic [XLEN-1:0]    reg_target;
  logic [15:0]        imm;
  logic [25:0]        jaddr;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_data;
  logic [XLEN-1:0]    inst;
  logic [XLEN-1:0]    inst_pc;
  logic               inst_valid;
  logic [XLEN-1:0]    pc_plus4;
  logic               misalign;

  // Fetch unit side
  modport master (
    input  stall, pc_sel, reg_target, imm, jaddr, imem_data,
    output imem_addr, inst, inst_pc, inst_valid, pc_plus4, misalign
  );

  // Environment side: pipeline control and instruction memory
  modport slave (
    output stall, pc_sel, reg_target, imm, jaddr, imem_data,
    input  imem_addr, inst, inst_pc, inst_valid, pc_plus4, misalign
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register driving a 1-cycle-latency instruction
// memory, an F2 register tracking the PC of the word arriving from memory,
// and a skid register that freezes the presented instruction during stalls.
module fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     IMEM_AW      = 6,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] f2_pc;
  logic            f2_valid;
  logic [XLEN-1:0] hold_data;
  logic            hold_vld;
  logic            misalign_q;

  logic [XLEN-1:0] link;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            bad_align;

  // Redirect target selection; operands are only meaningful when redirect is set
  always_comb begin
    link      = f2_pc + XLEN'(4);
    target    = '0;
    bad_align = 1'b0;
    redirect  = !bus.stall && f2_valid && (bus.pc_sel != 2'b00);
    case (bus.pc_sel)
      2'b01: begin
        target    = {bus.reg_target[XLEN-1:2], 2'b00};
        bad_align = (bus.reg_target[1:0] != 2'b00);
      end
      2'b10:   target = link + {{(XLEN-18){bus.imm[15]}}, bus.imm, 2'b00};
      2'b11:   target = {link[XLEN-1:28], bus.jaddr, 2'b00};
      default: target = '0;
    endcase
  end

  // PC, F2 and skid state; stall has priority over any redirect request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_VECTOR;
      f2_pc      <= RESET_VECTOR;
      f2_valid   <= 1'b0;
      hold_data  <= '0;
      hold_vld   <= 1'b0;
      misalign_q <= 1'b0;
    end else if (bus.stall) begin
      // Memory keeps re-reading pc, so capture the presented word only once
      if (!hold_vld) begin
        hold_data <= bus.imem_data;
        hold_vld  <= 1'b1;
      end
      misalign_q <= 1'b0;
    end else if (redirect) begin
      pc         <= target;
      f2_valid   <= 1'b0;
      hold_vld   <= 1'b0;
      misalign_q <= (bus.pc_sel == 2'b01) && bad_align;
    end else begin
      f2_pc      <= pc;
      f2_valid   <= 1'b1;
      pc         <= pc + XLEN'(4);
      hold_vld   <= 1'b0;
      misalign_q <= 1'b0;
    end
  end

  assign bus.imem_addr  = pc[IMEM_AW+1:2];
  assign bus.inst       = hold_vld ? hold_data : bus.imem_data;
  assign bus.inst_pc    = f2_pc;
  assign bus.inst_valid = f2_valid;
  assign bus.pc_plus4   = link;
  assign bus.misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the basic fetch/stall/redirect
// scenarios with literal expectations, then randomized control traffic
// compared every cycle against an instruction-stream model.
module tb_fetch_unit;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned IMEM_AW = 6;
  localparam logic [31:0] RV      = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [64];

  fetch_if #(.XLEN(XLEN), .IMEM_AW(IMEM_AW)) bus ();

  fetch_unit #(.XLEN(XLEN), .IMEM_AW(IMEM_AW), .RESET_VECTOR(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, one cycle read latency
  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Instruction-stream model: which PC is on show, whether it is valid,
  // and where fetch resumes after a taken redirect.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = RV;
  logic [31:0] m_next  = RV;
  logic        m_mis   = 1'b0;

  function automatic logic [31:0] target_of(input logic [31:0] lnk, input logic [1:0] sel,
                                            input logic [31:0] rt, input logic [15:0] im,
                                            input logic [25:0] ja);
    int off;
    off = $signed(im);
    case (sel)
      2'd1:    return rt & ~32'h3;
      2'd2:    return lnk + 32'(off * 4);
      default: return (lnk & 32'hF000_0000) | (32'(ja) << 2);
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_pc    <= RV;
      m_next  <= RV;
      m_mis   <= 1'b0;
    end else begin
      m_mis <= 1'b0;
      if (!bus.stall) begin
        if (m_valid && bus.pc_sel != 2'd0) begin
          m_next  <= target_of(m_pc + 32'd4, bus.pc_sel, bus.reg_target, bus.imm, bus.jaddr);
          m_valid <= 1'b0;
          m_mis   <= (bus.pc_sel == 2'd1) && (bus.reg_target[1:0] != 2'd0);
        end else if (m_valid) begin
          m_pc <= m_pc + 32'd4;
        end else begin
          m_valid <= 1'b1;
          m_pc    <= m_next;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [31:0] fetch_pc;
    logic [5:0]  widx;
    fetch_pc = m_valid ? m_pc + 32'd4 : m_next;
    widx     = m_pc[7:2];
    chk("inst_valid", 32'(bus.inst_valid), 32'(m_valid));
    chk("misalign", 32'(bus.misalign), 32'(m_mis));
    chk("imem_addr", 32'(bus.imem_addr), {26'd0, fetch_pc[7:2]});
    if (m_valid) begin
      chk("inst_pc", bus.inst_pc, m_pc);
      chk("inst", bus.inst, mem[widx]);
      chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    end
    if (rst) begin
      chk("rst_inst_pc", bus.inst_pc, RV);
      chk("rst_pc_plus4", bus.pc_plus4, RV + 32'd4);
    end
  end

  task automatic step(input logic s, input logic [1:0] sel, input logic [31:0] rt,
                      input logic [15:0] im, input logic [25:0] ja);
    bus.stall      = s;
    bus.pc_sel     = sel;
    bus.reg_target = rt;
    bus.imm        = im;
    bus.jaddr      = ja;
    @(negedge clk);
    #1;
  endtask

  task automatic lit_inst(input string name, input logic [31:0] pc, input logic [31:0] ins);
    chk({name, "_valid"}, 32'(bus.inst_valid), 32'd1);
    chk({name, "_pc"}, bus.inst_pc, pc);
    chk({name, "_inst"}, bus.inst, ins);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + 32'(i);
    bus.stall      = 1'b0;
    bus.pc_sel     = 2'd0;
    bus.reg_target = '0;
    bus.imm        = '0;
    bus.jaddr      = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("reset_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("reset_inst_pc", bus.inst_pc, 32'd0);
    chk("reset_pc_plus4", bus.pc_plus4, 32'd4);
    chk("reset_misalign", 32'(bus.misalign), 32'd0);
    rst = 1'b0;

    // Sequential run
    step(0, 0, 0, 0, 0); lit_inst("first", 32'd0, 32'h1000);
    step(0, 0, 0, 0, 0); lit_inst("seq4", 32'd4, 32'h1001);
    step(0, 0, 0, 0, 0); lit_inst("seq8", 32'd8, 32'h1002);
    // Three stalled cycles at pc 8
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0); lit_inst("stall8", 32'd8, 32'h1002);
    end
    step(0, 0, 0, 0, 0); lit_inst("after_stall", 32'd12, 32'h1003);
    // Stall beats a branch request
    step(1, 2'd2, 0, 16'hFFFE, 0); lit_inst("stall_vs_branch", 32'd12, 32'h1003);
    // Misaligned register jump
    step(0, 2'd1, 32'h23, 0, 0);
    chk("jr_bubble", 32'(bus.inst_valid), 32'd0);
    chk("jr_misalign", 32'(bus.misalign), 32'd1);
    step(0, 0, 0, 0, 0); lit_inst("jr_target", 32'h20, 32'h1008);
    chk("jr_misalign_end", 32'(bus.misalign), 32'd0);
    // Back to 8, then backward branch
    step(0, 2'd1, 32'h8, 0, 0);
    step(0, 0, 0, 0, 0); lit_inst("jr8", 32'd8, 32'h1002);
    step(0, 2'd2, 0, 16'hFFFE, 0);
    chk("br_back_bubble", 32'(bus.inst_valid), 32'd0);
    step(0, 0, 0, 0, 0); lit_inst("br_back", 32'd4, 32'h1001);
    step(0, 0, 0, 0, 0); lit_inst("br_seq", 32'd8, 32'h1002);
    step(0, 2'd2, 0, 16'h0003, 0);
    chk("br_fwd_bubble", 32'(bus.inst_valid), 32'd0);
    step(0, 0, 0, 0, 0); lit_inst("br_fwd", 32'd24, 32'h1006);
    // Absolute jump to the last word, then wrap
    step(0, 2'd1, 32'h10, 0, 0);
    step(0, 0, 0, 0, 0); lit_inst("jr10", 32'h10, 32'h1004);
    step(0, 2'd3, 0, 0, 26'h3F);
    step(0, 0, 0, 0, 0); lit_inst("jump", 32'hFC, 32'h103F);
    chk("wrap_imem_addr", 32'(bus.imem_addr), 32'd0);
    step(0, 0, 0, 0, 0); lit_inst("wrap", 32'h100, 32'h1000);
    chk("wrap_pc_plus4", bus.pc_plus4, 32'h104);
    // Reset in the middle of a stall
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("midstall_rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("midstall_rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("midstall_rst_pc", bus.inst_pc, RV);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0, 0, 0); lit_inst("post_rst", 32'd0, 32'h1000);

    // Fresh memory contents loaded under reset, then random traffic
    rst = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic       s;
      logic [1:0] sel;
      s   = ($urandom_range(0, 3) == 0);
      sel = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        step(s, sel, $urandom, 16'($urandom), 26'($urandom));
        rst = 1'b0;
      end else begin
        step(s, sel, $urandom, 16'($urandom), 26'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
